// File: rtl/dm_cache_refill_if.sv
// Handshake bundle between the refill controller, the miss logic, memory and the data BRAM.
// The master modport is the controller's view; slave is the environment's.
interface dm_cache_refill_if #(
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LINE_W = 128
);
    logic              req_valid;
    logic              req_ready;
    logic [IDX_W-1:0]  req_index;
    logic              req_dirty;
    logic              busy;
    logic              done;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [IDX_W-1:0]  mem_req_index;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [WORD_W-1:0] mem_rdata;
    logic              bram_ena;
    logic              bram_wea;
    logic [IDX_W-1:0]  bram_addra;
    logic [LINE_W-1:0] bram_dina;
    logic [LINE_W-1:0] bram_douta;

    modport master (
        input  req_valid, req_index, req_dirty, mem_req_ready, mem_rvalid, mem_rdata, bram_douta,
        output req_ready, busy, done, mem_req_valid, mem_req_we, mem_req_index, mem_wdata,
               bram_ena, bram_wea, bram_addra, bram_dina
    );

    modport slave (
        output req_valid, req_index, req_dirty, mem_req_ready, mem_rvalid, mem_rdata, bram_douta,
        input  req_ready, busy, done, mem_req_valid, mem_req_we, mem_req_index, mem_wdata,
               bram_ena, bram_wea, bram_addra, bram_dina
    );
endinterface

// File: rtl/dm_cache_refill_ctrl.sv
// Direct-mapped cache line refill / write-back controller. Owns the data BRAM port while busy:
// optional victim read-out and write-back, then beat-wise fill and a single-cycle line write.
module dm_cache_refill_ctrl #(
    parameter int unsigned SET_NUM        = 32,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned WORD_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    dm_cache_refill_if.master bus
);
    localparam int unsigned IDX_W  = $clog2(SET_NUM);
    localparam int unsigned LINE_W = WORDS_PER_LINE * WORD_W;
    localparam int unsigned CNT_W  = $clog2(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] LastBeat = CNT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        StIdle, StWbRd, StWbCap, StWbReq, StFillReq, StFillBeat, StWrite, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] victim_q, victim_d;
    logic [LINE_W-1:0] line_q, line_d;

    logic ready_q, ready_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic mreq_valid_q, mreq_valid_d;
    logic mreq_we_q, mreq_we_d;
    logic ena_q, ena_d;
    logic wea_q, wea_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        victim_d = victim_q;
        line_d   = line_q;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    idx_d   = bus.req_index;
                    cnt_d   = '0;
                    state_d = bus.req_dirty ? StWbRd : StFillReq;
                end
            end
            StWbRd:  state_d = StWbCap;
            StWbCap: begin
                // BRAM read latency is one cycle: data requested in StWbRd is valid now
                victim_d = bus.bram_douta;
                state_d  = StWbReq;
            end
            StWbReq:   if (bus.mem_req_ready) state_d = StFillReq;
            StFillReq: if (bus.mem_req_ready) state_d = StFillBeat;
            StFillBeat: begin
                if (bus.mem_rvalid) begin
                    line_d[int'(cnt_q)*WORD_W +: WORD_W] = bus.mem_rdata;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LastBeat) state_d = StWrite;
                end
            end
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state, so they line up with state_q
        ready_d      = (state_d == StIdle);
        busy_d       = (state_d != StIdle);
        done_d       = (state_d == StDone);
        mreq_valid_d = (state_d == StWbReq) || (state_d == StFillReq);
        mreq_we_d    = (state_d == StWbReq);
        ena_d        = (state_d == StWbRd) || (state_d == StWrite);
        wea_d        = (state_d == StWrite);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cnt_q        <= '0;
            victim_q     <= '0;
            line_q       <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mreq_valid_q <= 1'b0;
            mreq_we_q    <= 1'b0;
            ena_q        <= 1'b0;
            wea_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            victim_q     <= victim_d;
            line_q       <= line_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mreq_valid_q <= mreq_valid_d;
            mreq_we_q    <= mreq_we_d;
            ena_q        <= ena_d;
            wea_q        <= wea_d;
        end
    end

    assign bus.req_ready     = ready_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.mem_req_valid = mreq_valid_q;
    assign bus.mem_req_we    = mreq_we_q;
    assign bus.mem_req_index = idx_q;
    assign bus.mem_wdata     = victim_q;
    assign bus.bram_ena      = ena_q;
    assign bus.bram_wea      = wea_q;
    assign bus.bram_addra    = idx_q;
    assign bus.bram_dina     = line_q;
endmodule

// File: tb/tb_dm_cache_refill_ctrl.sv
// Directed bench for dm_cache_refill_ctrl with a behavioural 1-cycle-latency BRAM model.
module tb_dm_cache_refill_ctrl;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LINE_W = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int t0   = 0;

    logic [LINE_W-1:0] mem [32];

    dm_cache_refill_if #(.IDX_W(IDX_W), .WORD_W(WORD_W), .LINE_W(LINE_W)) bif ();

    dm_cache_refill_ctrl #(.SET_NUM(32), .WORDS_PER_LINE(4), .WORD_W(WORD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    function automatic logic [LINE_W-1:0] victim_of(input int i);
        return {16'hDEAD, 8'(i), 88'h0, 16'hBEEF};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= victim_of(i);
            bif.bram_douta <= '0;
        end else if (bif.bram_ena) begin
            if (bif.bram_wea) mem[bif.bram_addra] <= bif.bram_dina;
            else              bif.bram_douta <= mem[bif.bram_addra];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic v, input logic [WORD_W-1:0] d);
        bif.mem_rvalid = v;
        bif.mem_rdata  = d;
        step();
        bif.mem_rvalid = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (bif.done !== 1'b1 && n < max) begin
            step();
            n++;
        end
        chkb("done_seen", bif.done, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chkb({tag, "_req_ready"}, bif.req_ready, 1'b1);
        chkb({tag, "_busy"}, bif.busy, 1'b0);
        chkb({tag, "_done"}, bif.done, 1'b0);
        chkb({tag, "_mreq_valid"}, bif.mem_req_valid, 1'b0);
        chkb({tag, "_mreq_we"}, bif.mem_req_we, 1'b0);
        chkb({tag, "_ena"}, bif.bram_ena, 1'b0);
        chkb({tag, "_wea"}, bif.bram_wea, 1'b0);
        chki({tag, "_mreq_index"}, int'(bif.mem_req_index), 0);
        chki({tag, "_addra"}, int'(bif.bram_addra), 0);
        chk({tag, "_wdata"}, bif.mem_wdata, '0);
        chk({tag, "_dina"}, bif.bram_dina, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bif.req_valid     = 1'b0;
        bif.req_index     = '0;
        bif.req_dirty     = 1'b0;
        bif.mem_req_ready = 1'b0;
        bif.mem_rvalid    = 1'b0;
        bif.mem_rdata     = '0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #20 rst = 1'b0;
        step();
        chk_reset_outputs("por");

        // Clean fill to index 5, zero wait states
        bif.mem_req_ready = 1'b1;
        bif.req_index = 5'd5; bif.req_dirty = 1'b0; bif.req_valid = 1'b1;
        t0 = cyc;
        step();
        bif.req_valid = 1'b0;
        chkb("clean_fillreq_valid", bif.mem_req_valid, 1'b1);
        chkb("clean_fillreq_we", bif.mem_req_we, 1'b0);
        chki("clean_fillreq_index", int'(bif.mem_req_index), 5);
        chkb("clean_busy", bif.busy, 1'b1);
        chkb("clean_ready_low", bif.req_ready, 1'b0);
        step();
        beat(1'b1, 32'h11111111);
        beat(1'b1, 32'h22222222);
        beat(1'b1, 32'h33333333);
        beat(1'b1, 32'h44444444);
        chki("clean_write_cycle", cyc - t0, 6);
        chkb("clean_write_wea", bif.bram_wea, 1'b1);
        chkb("clean_write_ena", bif.bram_ena, 1'b1);
        chki("clean_write_addra", int'(bif.bram_addra), 5);
        chk("clean_write_dina", bif.bram_dina, 128'h44444444_33333333_22222222_11111111);
        chkb("clean_no_early_done", bif.done, 1'b0);
        step();
        chkb("clean_done", bif.done, 1'b1);
        chki("clean_done_cycle", cyc - t0, 7);
        step();
        chkb("clean_done_pulse_end", bif.done, 1'b0);
        chkb("clean_back_idle", bif.req_ready, 1'b1);
        chk("clean_bram_mem", mem[5], 128'h44444444_33333333_22222222_11111111);

        // Dirty fill to index 31
        bif.req_index = 5'd31; bif.req_dirty = 1'b1; bif.req_valid = 1'b1;
        t0 = cyc;
        step();
        bif.req_valid = 1'b0;
        chkb("dirty_rd_ena", bif.bram_ena, 1'b1);
        chkb("dirty_rd_wea", bif.bram_wea, 1'b0);
        chki("dirty_rd_addra", int'(bif.bram_addra), 31);
        step();
        chkb("dirty_cap_no_req", bif.mem_req_valid, 1'b0);
        step();
        chkb("dirty_wb_valid", bif.mem_req_valid, 1'b1);
        chkb("dirty_wb_we", bif.mem_req_we, 1'b1);
        chk("dirty_wb_wdata", bif.mem_wdata, 128'hDEAD1F00_00000000_00000000_0000BEEF);
        step();
        chkb("dirty_fill_valid", bif.mem_req_valid, 1'b1);
        chkb("dirty_fill_we", bif.mem_req_we, 1'b0);
        step();
        beat(1'b1, 32'hA0000001);
        beat(1'b1, 32'hA0000002);
        beat(1'b1, 32'hA0000003);
        beat(1'b1, 32'hA0000004);
        chkb("dirty_write_wea", bif.bram_wea, 1'b1);
        chki("dirty_write_addra", int'(bif.bram_addra), 31);
        chk("dirty_write_dina", bif.bram_dina, 128'hA0000004_A0000003_A0000002_A0000001);
        wait_done(5);
        chki("dirty_done_cycle", cyc - t0, 10);
        chk("dirty_bram_mem", mem[31], 128'hA0000004_A0000003_A0000002_A0000001);
        step();

        // Backpressure: 5 stalled cycles in each request state
        bif.mem_req_ready = 1'b0;
        bif.req_index = 5'd7; bif.req_dirty = 1'b1; bif.req_valid = 1'b1;
        t0 = cyc;
        step();
        bif.req_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chkb("bp_wb_valid", bif.mem_req_valid, 1'b1);
            chkb("bp_wb_we", bif.mem_req_we, 1'b1);
            chk("bp_wb_wdata", bif.mem_wdata, victim_of(7));
            step();
        end
        bif.mem_req_ready = 1'b1;
        step();
        bif.mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chkb("bp_fill_valid", bif.mem_req_valid, 1'b1);
            chkb("bp_fill_we", bif.mem_req_we, 1'b0);
            chki("bp_fill_index", int'(bif.mem_req_index), 7);
            step();
        end
        bif.mem_req_ready = 1'b1;
        step();
        beat(1'b1, 32'hB0000001);
        beat(1'b1, 32'hB0000002);
        beat(1'b1, 32'hB0000003);
        beat(1'b1, 32'hB0000004);
        wait_done(5);
        chki("bp_done_cycle", cyc - t0, 20);
        step();

        // Stray beats while idle must not touch the line buffer
        bif.mem_rvalid = 1'b1; bif.mem_rdata = 32'hBAD0BAD0;
        step(); step(); step();
        bif.mem_rvalid = 1'b0;
        chkb("stray_idle_ready", bif.req_ready, 1'b1);
        chkb("stray_idle_busy", bif.busy, 1'b0);
        chk("stray_idle_dina", bif.bram_dina, 128'hB0000004_B0000003_B0000002_B0000001);

        // Gapped beats, plus a stray beat during the fill request
        bif.req_index = 5'd9; bif.req_dirty = 1'b0; bif.req_valid = 1'b1;
        t0 = cyc;
        step();
        bif.req_valid = 1'b0;
        beat(1'b1, 32'hBAD00001);
        beat(1'b1, 32'hC0000001);
        beat(1'b0, 32'hBAD00002);
        beat(1'b0, 32'hBAD00003);
        beat(1'b1, 32'hC0000002);
        beat(1'b1, 32'hC0000003);
        beat(1'b0, 32'hBAD00004);
        beat(1'b1, 32'hC0000004);
        chkb("gap_write_wea", bif.bram_wea, 1'b1);
        chki("gap_write_cycle", cyc - t0, 9);
        chk("gap_write_dina", bif.bram_dina, 128'hC0000004_C0000003_C0000002_C0000001);
        wait_done(3);
        step();

        // Reset after two beats of a fill
        bif.req_index = 5'd12; bif.req_dirty = 1'b0; bif.req_valid = 1'b1;
        step();
        bif.req_valid = 1'b0;
        step();
        beat(1'b1, 32'hD0000001);
        beat(1'b1, 32'hD0000002);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        rst = 1'b0;
        step();
        chkb("midrst_still_idle", bif.busy, 1'b0);
        bif.req_index = 5'd3; bif.req_valid = 1'b1;
        step();
        bif.req_valid = 1'b0;
        step();
        beat(1'b1, 32'hE0000001);
        beat(1'b1, 32'hE0000002);
        beat(1'b1, 32'hE0000003);
        beat(1'b1, 32'hE0000004);
        chki("postrst_addra", int'(bif.bram_addra), 3);
        chk("postrst_dina", bif.bram_dina, 128'hE0000004_E0000003_E0000002_E0000001);
        wait_done(3);
        step();

        // Back-to-back misses with req_valid held high
        bif.req_index = 5'd20; bif.req_dirty = 1'b0; bif.req_valid = 1'b1;
        step();
        bif.req_index = 5'd21;
        chkb("b2b_ready_low_c1", bif.req_ready, 1'b0);
        step();
        chkb("b2b_ready_low_c2", bif.req_ready, 1'b0);
        beat(1'b1, 32'hF0000001);
        beat(1'b1, 32'hF0000002);
        beat(1'b1, 32'hF0000003);
        beat(1'b1, 32'hF0000004);
        chkb("b2b_ready_low_write", bif.req_ready, 1'b0);
        chki("b2b_first_addra", int'(bif.bram_addra), 20);
        step();
        chkb("b2b_first_done", bif.done, 1'b1);
        chkb("b2b_ready_low_done", bif.req_ready, 1'b0);
        step();
        chkb("b2b_idle_ready", bif.req_ready, 1'b1);
        step();
        bif.req_valid = 1'b0;
        chkb("b2b_second_busy", bif.busy, 1'b1);
        chki("b2b_second_index", int'(bif.mem_req_index), 21);
        step();
        beat(1'b1, 32'h90000001);
        beat(1'b1, 32'h90000002);
        beat(1'b1, 32'h90000003);
        beat(1'b1, 32'h90000004);
        chki("b2b_second_addra", int'(bif.bram_addra), 21);
        chk("b2b_second_dina", bif.bram_dina, 128'h90000004_90000003_90000002_90000001);
        wait_done(3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
